// File: rtl/phase_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : phase_tick_gen
//  Brief    : Programmable timebase. Emits a 1-cycle tick every div_cur enabled
//             cycles. Supports pause, clear, and divisor reload deferred to the
//             next tick boundary.
//  Revision : 1.0 - initial release
// ============================================================================
module phase_tick_gen #(
   parameter int unsigned CNT_W       = 27,
   parameter int unsigned DEFAULT_DIV = 100_000_000,
   parameter int unsigned TCNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic              div_load,
   input  logic [CNT_W-1:0]  div_in,
   output logic              div_busy,
   output logic [CNT_W-1:0]  div_cur,
   output logic              tick,
   output logic [TCNT_W-1:0] tick_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      RUN_PEND = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  DIV_RESET = CNT_W'(DEFAULT_DIV);
   localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] pend;
   // Remembers a deferred divisor across a pause, since IDLE alone cannot.
   logic             parked;

   logic             pending;
   logic             boundary;
   logic             hit;
   logic [CNT_W-1:0] ld_val;

   assign pending  = (state == RUN_PEND) | parked;
   assign boundary = (cnt == (div_cur - CNT_ONE));
   assign hit      = en & ~clr & boundary;
   assign ld_val   = (div_in == '0) ? CNT_ONE : div_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         pend       <= '0;
         parked     <= 1'b0;
         div_cur    <= DIV_RESET;
         div_busy   <= 1'b0;
         tick       <= 1'b0;
         tick_count <= '0;
      end else if (!en) begin
         state <= IDLE;
         tick  <= 1'b0;
         if (div_load) begin
            // Paused: the new rate takes effect immediately from a fresh period.
            div_cur  <= ld_val;
            cnt      <= '0;
            parked   <= 1'b0;
            div_busy <= 1'b0;
         end else begin
            if (clr) begin
               cnt <= '0;
            end
            parked   <= pending;
            div_busy <= pending;
         end
      end else if (hit) begin
         state      <= RUN;
         tick       <= 1'b1;
         cnt        <= '0;
         tick_count <= tick_count + TCNT_ONE;
         parked     <= 1'b0;
         div_busy   <= 1'b0;
         if (div_load) begin
            div_cur <= ld_val;
         end else if (pending) begin
            div_cur <= pend;
         end
      end else begin
         tick   <= 1'b0;
         parked <= 1'b0;
         cnt    <= clr ? '0 : (cnt + CNT_ONE);
         if (div_load) begin
            pend <= ld_val;
         end
         div_busy <= pending | div_load;
         state    <= (pending | div_load) ? RUN_PEND : RUN;
      end
   end

endmodule
`default_nettype wire
